// File: rtl/visited_bitmap_ctrl.sv
// visited_bitmap_ctrl
//   Serialises candidate node IDs against the visited bitmap held in block RAM:
//   read the bitmap word, hand it to the external visited_checker, write the
//   updated word back on a first visit and report the result. Also clears the
//   whole bitmap on command and counts first visits since the last clear.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   clear_start / clear_done   bitmap clear command / pulse on last clear write
//   busy                       high whenever not idle
//   req_valid/ready/node       candidate node input handshake
//   resp_valid/ready/node/new  result handshake, resp_new=1 on first visit
//   new_count                  first visits since the last clear
//   bram_*                     single-port bitmap RAM (1-cycle read latency)
//   chk_*                      visited_checker drive and registered results
module visited_bitmap_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear_start,
  output logic                    clear_done,
  output logic                    busy,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_node,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ADDR_WIDTH-1:0]   resp_node,
  output logic                    resp_new,
  output logic [ADDR_WIDTH:0]     new_count,
  output logic                    bram_en,
  output logic                    bram_we,
  output logic [ADDR_WIDTH-6:0]   bram_addr,
  output logic [DATA_WIDTH-1:0]   bram_wdata,
  input  logic [DATA_WIDTH-1:0]   bram_rdata,
  output logic                    chk_en,
  output logic [ADDR_WIDTH-1:0]   chk_node_addr,
  output logic [DATA_WIDTH-1:0]   chk_bitmask_in,
  input  logic [DATA_WIDTH-1:0]   chk_bitmask_out,
  input  logic                    chk_visited,
  input  logic                    chk_update_en
);

  localparam int WA = ADDR_WIDTH - 5;
  localparam logic [WA-1:0] LAST_WORD = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_RD, S_CAP, S_CHK, S_UPD, S_RESP
  } state_t;

  state_t                  r_state;
  logic                    r_idle_rdy;
  logic [ADDR_WIDTH-1:0]   r_node;
  logic [DATA_WIDTH-1:0]   r_word;
  logic [WA-1:0]           r_cnt;
  logic [ADDR_WIDTH:0]     r_new_count;
  logic                    r_bram_en;
  logic                    r_bram_we;
  logic [WA-1:0]           r_bram_addr;
  logic [DATA_WIDTH-1:0]   r_bram_wdata;
  logic                    r_clear_done;
  logic                    r_chk_en;
  logic [ADDR_WIDTH-1:0]   r_chk_node_addr;
  logic [DATA_WIDTH-1:0]   r_chk_bitmask_in;
  logic                    r_resp_valid;
  logic [ADDR_WIDTH-1:0]   r_resp_node;
  logic                    r_resp_new;
  logic                    w_upd_wr;

  // Checker results are only valid during UPD, so the write-back is decoded
  // from them directly in that cycle rather than registered. A checker that
  // reports the bit as already set never triggers a write.
  assign w_upd_wr = (r_state == S_UPD) && chk_update_en && !chk_visited;

  assign bram_en        = r_bram_en | w_upd_wr;
  assign bram_we        = r_bram_we | w_upd_wr;
  assign bram_addr      = w_upd_wr ? r_node[ADDR_WIDTH-1:5] : r_bram_addr;
  assign bram_wdata     = w_upd_wr ? chk_bitmask_out : r_bram_wdata;
  assign clear_done     = r_clear_done;
  assign busy           = (r_state != S_IDLE);
  // r_idle_rdy keeps req_ready low in the cycle reset is released.
  assign req_ready      = r_idle_rdy & ~clear_start;
  assign resp_valid     = r_resp_valid;
  assign resp_node      = r_resp_node;
  assign resp_new       = r_resp_new;
  assign new_count      = r_new_count;
  assign chk_en         = r_chk_en;
  assign chk_node_addr  = r_chk_node_addr;
  assign chk_bitmask_in = r_chk_bitmask_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_idle_rdy       <= 1'b0;
      r_node           <= '0;
      r_word           <= '0;
      r_cnt            <= '0;
      r_new_count      <= '0;
      r_bram_en        <= 1'b0;
      r_bram_we        <= 1'b0;
      r_bram_addr      <= '0;
      r_bram_wdata     <= '0;
      r_clear_done     <= 1'b0;
      r_chk_en         <= 1'b0;
      r_chk_node_addr  <= '0;
      r_chk_bitmask_in <= '0;
      r_resp_valid     <= 1'b0;
      r_resp_node      <= '0;
      r_resp_new       <= 1'b0;
    end else begin
      // Strobe-style outputs are asserted only for the state being entered.
      r_bram_en        <= 1'b0;
      r_bram_we        <= 1'b0;
      r_bram_addr      <= '0;
      r_bram_wdata     <= '0;
      r_clear_done     <= 1'b0;
      r_chk_en         <= 1'b0;
      r_chk_node_addr  <= '0;
      r_chk_bitmask_in <= '0;

      case (r_state)
        S_IDLE: begin
          if (!r_idle_rdy) begin
            r_idle_rdy <= 1'b1;
          end else if (clear_start) begin
            r_state      <= S_CLEAR;
            r_idle_rdy   <= 1'b0;
            r_new_count  <= '0;
            r_cnt        <= '0;
            r_bram_en    <= 1'b1;
            r_bram_we    <= 1'b1;
            r_clear_done <= (LAST_WORD == '0);
          end else if (req_valid) begin
            r_state     <= S_RD;
            r_idle_rdy  <= 1'b0;
            r_node      <= req_node;
            r_bram_en   <= 1'b1;
            r_bram_addr <= req_node[ADDR_WIDTH-1:5];
          end
        end

        S_CLEAR: begin
          if (r_cnt == LAST_WORD) begin
            r_state    <= S_IDLE;
            r_idle_rdy <= 1'b1;
          end else begin
            r_cnt        <= r_cnt + 1'b1;
            r_bram_en    <= 1'b1;
            r_bram_we    <= 1'b1;
            r_bram_addr  <= r_cnt + 1'b1;
            r_clear_done <= ((r_cnt + 1'b1) == LAST_WORD);
          end
        end

        S_RD: r_state <= S_CAP;

        S_CAP: begin
          r_word           <= bram_rdata;
          r_state          <= S_CHK;
          r_chk_en         <= 1'b1;
          r_chk_node_addr  <= r_node;
          r_chk_bitmask_in <= bram_rdata;
        end

        S_CHK: r_state <= S_UPD;

        S_UPD: begin
          r_state      <= S_RESP;
          r_resp_valid <= 1'b1;
          r_resp_node  <= r_node;
          r_resp_new   <= w_upd_wr;
          if (w_upd_wr) r_new_count <= r_new_count + 1'b1;
        end

        S_RESP: begin
          if (resp_ready) begin
            r_state      <= S_IDLE;
            r_idle_rdy   <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_node  <= '0;
            r_resp_new   <= 1'b0;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_visited_bitmap_ctrl.sv
module tb_visited_bitmap_ctrl;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear_start = 1'b0;
  logic          clear_done;
  logic          busy;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_node = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [AW-1:0] resp_node;
  logic          resp_new;
  logic [AW:0]   new_count;
  logic          bram_en, bram_we;
  logic [AW-6:0] bram_addr;
  logic [31:0]   bram_wdata;
  logic [31:0]   bram_rdata = '0;
  logic          chk_en;
  logic [AW-1:0] chk_node_addr;
  logic [31:0]   chk_bitmask_in;
  logic [31:0]   chk_bitmask_out = '0;
  logic          chk_visited = 1'b0;
  logic          chk_update_en = 1'b0;
  logic          kill_chk = 1'b0;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  typedef struct packed { logic [4:0] addr; logic [31:0] data; } wr_t;
  typedef struct packed { logic [AW-1:0] node; logic nw; } rsp_t;
  wr_t  wr_q[$];
  rsp_t resp_q[$];

  logic [31:0] exp_bm [32];
  int unsigned exp_cnt = 0;
  logic [31:0] mem [32];

  visited_bitmap_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .clear_start(clear_start), .clear_done(clear_done),
    .busy(busy), .req_valid(req_valid), .req_ready(req_ready), .req_node(req_node),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_node(resp_node),
    .resp_new(resp_new), .new_count(new_count), .bram_en(bram_en), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
    .chk_en(chk_en), .chk_node_addr(chk_node_addr), .chk_bitmask_in(chk_bitmask_in),
    .chk_bitmask_out(chk_bitmask_out), .chk_visited(chk_visited),
    .chk_update_en(chk_update_en)
  );

  always #5 clk = ~clk;

  // Block RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_wdata;
      else         bram_rdata <= mem[bram_addr];
    end
  end

  // visited_checker: registered, results valid the cycle after chk_en.
  always @(posedge clk) begin
    if (chk_en && !kill_chk) begin
      chk_bitmask_out <= chk_bitmask_in | (32'h1 << chk_node_addr[4:0]);
      chk_visited     <= chk_bitmask_in[chk_node_addr[4:0]];
      chk_update_en   <= !chk_bitmask_in[chk_node_addr[4:0]];
    end else begin
      chk_bitmask_out <= chk_bitmask_in;
      chk_visited     <= 1'b0;
      chk_update_en   <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write scoreboard: every BRAM write must match the head of wr_q.
  always @(negedge clk) begin
    if (bram_en && bram_we) begin
      check("wr_pending", (wr_q.size() > 0), 1'b1);
      if (wr_q.size() > 0) begin
        wr_t e;
        e = wr_q.pop_front();
        check("wr_addr", bram_addr, e.addr);
        check("wr_data", bram_wdata, e.data);
      end
    end
  end

  // Response scoreboard: resp_ready only changes just after posedge, so the
  // negedge sample matches what the next edge accepts.
  always @(negedge clk) begin
    if (resp_valid && resp_ready) begin
      check("resp_pending", (resp_q.size() > 0), 1'b1);
      if (resp_q.size() > 0) begin
        rsp_t e;
        e = resp_q.pop_front();
        check("resp_node", resp_node, e.node);
        check("resp_new", resp_new, e.nw);
      end
    end
  end

  task automatic do_clear(input bit with_req);
    @(negedge clk);
    clear_start = 1'b1;
    if (with_req) begin
      req_valid = 1'b1;
      req_node  = 10'd37;
    end
    #1 check("clr_req_ready_low", req_ready, 1'b0);
    for (int i = 0; i < 32; i++) wr_q.push_back('{addr: i[4:0], data: 32'h0});
    @(posedge clk);
    @(negedge clk);
    clear_start = 1'b0;
    req_valid   = 1'b0;
    for (int i = 0; i < 32; i++) begin
      check("clr_we", bram_we, 1'b1);
      check("clr_addr", bram_addr, i);
      check("clr_done", clear_done, (i == 31));
      check("clr_req_ready", req_ready, 1'b0);
      check("clr_busy", busy, 1'b1);
      @(negedge clk);
    end
    check("clr_end_busy", busy, 1'b0);
    check("clr_end_ready", req_ready, 1'b1);
    check("clr_end_done", clear_done, 1'b0);
    check("clr_new_count", new_count, 0);
    for (int i = 0; i < 32; i++) exp_bm[i] = '0;
    exp_cnt = 0;
  endtask

  task automatic do_req(input logic [AW-1:0] n, input int unsigned hold, input bit kill);
    logic [4:0]  a;
    logic [31:0] w;
    logic [31:0] m;
    bit          nw;
    a  = n[AW-1:5];
    w  = exp_bm[a];
    m  = 32'h1 << n[4:0];
    nw = ((w & m) == 0) && !kill;
    @(negedge clk);
    req_valid = 1'b1;
    req_node  = n;
    kill_chk  = kill;
    #1 check("req_ready", req_ready, 1'b1);
    resp_q.push_back('{node: n, nw: nw});
    if (nw) begin
      wr_q.push_back('{addr: a, data: w | m});
      exp_bm[a] = w | m;
      exp_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_node  = '0;
    check("rd_en", bram_en, 1'b1);
    check("rd_we", bram_we, 1'b0);
    check("rd_addr", bram_addr, a);
    check("rd_req_ready", req_ready, 1'b0);
    @(negedge clk);
    check("cap_bram_en", bram_en, 1'b0);
    check("cap_chk_en", chk_en, 1'b0);
    @(negedge clk);
    check("chk_en", chk_en, 1'b1);
    check("chk_node", chk_node_addr, n);
    check("chk_mask_in", chk_bitmask_in, w);
    @(negedge clk);
    check("upd_we", bram_we, nw);
    check("upd_resp_valid", resp_valid, 1'b0);
    if (hold > 0) begin
      @(posedge clk);
      #1 resp_ready = 1'b0;
    end
    @(negedge clk);
    check("resp_valid", resp_valid, 1'b1);
    check("new_count", new_count, exp_cnt);
    for (int unsigned k = 0; k < hold; k++) begin
      if (k > 0) @(negedge clk);
      check("hold_valid", resp_valid, 1'b1);
      check("hold_node", resp_node, n);
      check("hold_new", resp_new, nw);
      check("hold_req_ready", req_ready, 1'b0);
    end
    if (hold > 0) begin
      @(posedge clk);
      #1 resp_ready = 1'b1;
      @(negedge clk);
    end
    @(negedge clk);
    check("resp_done", resp_valid, 1'b0);
    kill_chk = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_bram_en", bram_en, 1'b0);
    check("rst_chk_en", chk_en, 1'b0);
    check("rst_new_count", new_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", req_ready, 1'b1);

    do_clear(1'b0);
    do_req(10'd37, 0, 1'b0);
    do_req(10'd37, 0, 1'b0);
    do_req(10'd36, 0, 1'b0);
    do_req(10'd1023, 3, 1'b0);
    do_req(10'd5, 0, 1'b1);
    check("count_after_seq", new_count, 3);

    do_clear(1'b1);
    do_req(10'd37, 0, 1'b0);

    // Reset asserted in UPD: no write-back, response dropped.
    @(negedge clk);
    req_valid = 1'b1;
    req_node  = 10'd100;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_bram_en", bram_en, 1'b0);
    check("mid_rst_bram_we", bram_we, 1'b0);
    check("mid_rst_chk_en", chk_en, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_resp_valid", resp_valid, 1'b0);
    check("mid_rst_req_ready", req_ready, 1'b0);
    check("mid_rst_count", new_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_ready_after", req_ready, 1'b1);
    check("mid_rst_resp_after", resp_valid, 1'b0);

    do_clear(1'b0);
    do_req(10'd100, 0, 1'b0);
    check("final_count", new_count, 1);

    repeat (3) @(negedge clk);
    check("resp_q_empty", resp_q.size(), 0);
    check("wr_q_empty", wr_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/visited_bitmap_ctrl.md
# visited_bitmap_ctrl

Controller for the visited-node bitmap in the BFS engine. It accepts candidate node IDs from neighbour expansion and fetches the matching 32-bit bitmap word from block RAM. It drives the `visited_checker` stage with that word, writes the updated word back, and returns a first-visit flag for frontier enqueue. It also clears the whole bitmap on command and keeps a count of newly visited nodes.

## Interface
- `ADDR_WIDTH`, 10, node ID width. Bitmap word address width is `ADDR_WIDTH-5`.
- `DATA_WIDTH`, 32, bitmap word width. Fixed at 32 because the bit offset is `node[4:0]`.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `clear_start` in 1: start a bitmap clear. Sampled only in IDLE.
- `clear_done` out 1: one-cycle pulse when the last clear write is issued.
- `busy` out 1: high in any state other than IDLE.
- `req_valid` in 1: a candidate node ID is presented.
- `req_ready` out 1: the block can accept a request.
- `req_node` in `ADDR_WIDTH`: the candidate node ID.
- `resp_valid` out 1: a result is presented.
- `resp_ready` in 1: downstream accepts the result.
- `resp_node` out `ADDR_WIDTH`: the node ID being reported.
- `resp_new` out 1: 1 means first visit (enqueue the node); 0 means already visited.
- `new_count` out `ADDR_WIDTH+1`: number of first visits since the last clear.
- `bram_en`, `bram_we` out 1: BRAM port enable and write enable.
- `bram_addr` out `ADDR_WIDTH-5`: BRAM word address.
- `bram_wdata` out 32: BRAM write data.
- `bram_rdata` in 32: BRAM read data. Valid the cycle after a read is issued.
- `chk_en` out 1: drives `check_en` of the checker.
- `chk_node_addr` out `ADDR_WIDTH`: drives `node_addr` of the checker.
- `chk_bitmask_in` out 32: drives `bitmask_in` of the checker.
- `chk_bitmask_out` in 32, `chk_visited` in 1, `chk_update_en` in 1: checker outputs. Registered; valid the cycle after `chk_en`.

## Operation
- States:
  - IDLE
  - CLEAR
  - RD (issue read)
  - CAP (capture the word into `word_reg`)
  - CHK (assert `chk_en`)
  - UPD (sample checker outputs; optionally write back)
  - RESP (hold the result)
- IDLE:
  - `req_ready`=1 only here, and only when `clear_start`=0.
  - If `clear_start`=1, go to CLEAR. Clear wins over a simultaneous `req_valid`.
  - Else if `req_valid`=1, latch `req_node` and go to RD.
- CLEAR:
  - Word counter runs from 0 to 2^(`ADDR_WIDTH`-5)-1, one word per cycle.
  - Each cycle: `bram_en`=`bram_we`=1, `bram_wdata`=0.
  - `clear_done`=1 in the cycle the last address is written; the next state is IDLE.
  - `new_count` is zeroed on entry to CLEAR.
- RD: `bram_en`=1, `bram_we`=0, `bram_addr`=`node[ADDR_WIDTH-1:5]`.
- CAP: `word_reg` <= `bram_rdata`.
- CHK: `chk_en`=1, `chk_node_addr`=node, `chk_bitmask_in`=`word_reg`.
- UPD:
  - If `chk_update_en`=1: `bram_en`=`bram_we`=1, same address, `bram_wdata`=`chk_bitmask_out`; `new_count` increments.
  - `resp_new` <= `chk_update_en`.
  - Go to RESP.
- RESP: `resp_valid`=1. On `resp_ready`=1, go to IDLE.
- Requests are fully serialized, one in flight at a time. There is therefore no read-after-write hazard on the same bitmap word.
- `new_count` wraps at 2^(`ADDR_WIDTH`+1). In practice it cannot exceed 2^`ADDR_WIDTH` between clears.
- Checker output with both `chk_visited`=0 and `chk_update_en`=0 in UPD is treated as already visited (`resp_new`=0, no write).
- `clear_start` outside IDLE is ignored.

## Timing
- Reset state:
  - State is IDLE.
  - All outputs are 0, including `req_ready`. `req_ready` rises the first cycle after `rst_n` deasserts.
  - `new_count`=0 and `word_reg`=0.
- Request latency:
  - Handshake in cycle T.
  - RD at T+1, CAP at T+2, CHK at T+3, UPD at T+4.
  - `resp_valid` from T+5.
- Minimum request period is 6 cycles.
- `resp_node` and `resp_new` stay stable while `resp_valid`=1 and `resp_ready`=0.
- `bram_*` and `chk_*` are 0 in every cycle not listed above.
- Clear accepted at T: writes occur T+1 through T+2^(`ADDR_WIDTH`-5). `clear_done` coincides with the final write. IDLE resumes the following cycle.
- Reset mid-operation:
  - Returns to IDLE immediately and drops any pending response.
  - No write-back is issued.
  - Bitmap contents are then undefined; software must issue a clear.

## Test plan
- Reset, then pulse `clear_start` (`ADDR_WIDTH`=10) -> 32 writes of 0 to addresses 0..31 on consecutive cycles; `clear_done` on the write to address 31; `new_count`=0.
- After the clear, request node 37 -> read of address 1; `chk_node_addr`=37, `chk_bitmask_in`=0; write of 0x00000020 to address 1; `resp_node`=37, `resp_new`=1 at T+5; `new_count`=1.
- Request node 37 again -> no write; `resp_new`=0; `new_count` stays 1. Then request node 36 -> write of 0x00000030 to address 1; `new_count`=2.
- Request node 1023 -> address 31, write 0x80000000. Hold `resp_ready` low for 3 cycles -> `resp_valid`, `resp_node` and `resp_new` are held; `req_ready`=0 throughout.
- `clear_start` and `req_valid` in the same IDLE cycle -> CLEAR entered, request not accepted, `req_ready`=0 until `clear_done`+1.
- Assert `rst_n` low during UPD -> no BRAM write, all outputs 0, IDLE; `req_ready`=1 on the first cycle after release.
